als_responder: RTL and testbench

SPI responder that emulates the ambient-light-sensor ADC (ADC081S021-style, 16-clock read frame) on the DE0-Nano. It sits on the sensor side of the 3-wire link, driving ALS_SDO in answer to ALS_CS/ALS_SCK from the ALS reader. It serves as a loopback target for bring-up and hardware-in-loop tests of the reader without the physical Pmod. Samples come from a host-written holding register, or from an internal ramp when that feature is compiled in.

---
 rtl/als_pkg.sv | 21 ++
 rtl/als_sync_edge.sv | 37 +++
 rtl/als_responder.sv | 144 ++++++++++++++
 tb/tb_als_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/als_pkg.sv
// Shared definitions for the ambient-light-sensor responder and its reader-side checker.
package als_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int LEAD_ZEROS   = 3;
  localparam int SAMPLE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } als_state_e;

  // Frame is {lead zeros, sample, trailing zeros}; callers truncate to their frame width.
  function automatic logic [31:0] build_frame(input logic [SAMPLE_WIDTH-1:0] sample,
                                              input int frame_bits,
                                              input int lead_zeros);
    return {24'd0, sample} << (frame_bits - lead_zeros - SAMPLE_WIDTH);
  endfunction

endpackage

// File: rtl/als_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulses for one asynchronous input pin.
module als_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [SYNC_STAGES:0]   r_vld;

  // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_vld  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are only reported once both compared values are real pin samples,
  // so a level already present at reset release never looks like an edge.
  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_vld[SYNC_STAGES] &  o_level & ~r_prev;
  assign o_fall  = r_vld[SYNC_STAGES] & ~o_level &  r_prev;

endmodule

// File: rtl/als_responder.sv
// SPI responder emulating the ADC081S021 light sensor; define ALS_RESPONDER_RAMP_EN
// to source samples from an internal ramp instead of the host holding register.
module als_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = als_pkg::FRAME_BITS,
  parameter int LEAD_ZEROS  = als_pkg::LEAD_ZEROS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       ALS_CS,
  input  logic       ALS_SCK,
  output logic       ALS_SDO,
  output logic       ALS_SDO_OE,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  import als_pkg::*;

  localparam logic [4:0] CNT_MAX = 5'(FRAME_BITS);

  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic w_load, w_fresh;
  logic [7:0] w_sample;
  logic [FRAME_BITS-1:0] w_frame;

  als_state_e            r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [4:0]            r_bit_cnt;
  logic r_armed, r_sdo, r_oe, r_busy, r_frame_done, r_underrun;

  als_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .i_async(ALS_CS),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  als_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .i_async(ALS_SCK),
    .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

  assign w_load  = (r_state == IDLE) && w_cs_fall;
  assign w_frame = FRAME_BITS'(build_frame(w_sample, FRAME_BITS, LEAD_ZEROS));

`ifdef ALS_RESPONDER_RAMP_EN
  logic [7:0] r_ramp;
  logic       w_host_unused;

  assign w_host_unused = ^{sample, sample_valid};

  // Only completed frames advance the ramp; aborts never reach frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_ramp <= 8'h00;
    else if (r_frame_done) r_ramp <= r_ramp + 8'd1;
  end

  assign w_sample = r_ramp;
  assign w_fresh  = 1'b1;
`else
  logic [7:0] r_hold;
  logic       r_fresh;

  // NOTE: the holding register is ordinary state, not a RAM, so it takes the async reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold  <= 8'h00;
      r_fresh <= 1'b0;
    end else if (sample_valid) begin
      r_hold  <= sample;
      r_fresh <= 1'b1;
    end else if (w_load) begin
      r_fresh <= 1'b0;
    end
  end

  assign w_sample = r_hold;
  assign w_fresh  = r_fresh;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_armed      <= 1'b0;
      r_sdo        <= 1'b0;
      r_oe         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      if (w_cs_rise) begin
        r_state <= IDLE;
        r_oe    <= 1'b0;
        r_sdo   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_oe <= 1'b0;
            if (w_cs_fall) begin
              r_shift    <= w_frame;
              r_sdo      <= w_frame[FRAME_BITS-1];
              r_oe       <= 1'b1;
              r_busy     <= 1'b1;
              r_bit_cnt  <= '0;
              r_armed    <= 1'b0;
              r_underrun <= ~w_fresh;
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            // A fall without a preceding rise is the idle-high leading edge; skip it.
            if (!w_cs_level && w_sck_rise) begin
              if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 5'd1;
              r_armed <= 1'b1;
              if (r_bit_cnt == CNT_MAX - 5'd1) begin
                r_frame_done <= 1'b1;
                r_sdo        <= 1'b0;
                r_state      <= DONE;
              end
            end else if (!w_cs_level && w_sck_fall && r_armed) begin
              r_shift <= r_shift << 1;
              r_sdo   <= r_shift[FRAME_BITS-2];
              r_armed <= 1'b0;
            end
          end
          DONE:    r_sdo   <= 1'b0;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign ALS_SDO    = r_sdo;
  assign ALS_SDO_OE = r_oe;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_als_responder.sv
// Self-checking bench for als_responder: a reader model clocks frames against a sample/fresh reference.
module tb_als_responder;

  localparam int NBITS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample;
  logic       sample_valid;
  logic       ALS_CS, ALS_SCK;
  logic       ALS_SDO, ALS_SDO_OE, busy, frame_done, underrun;

  always #10 clk = ~clk;

  als_responder dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
    .ALS_CS(ALS_CS), .ALS_SCK(ALS_SCK), .ALS_SDO(ALS_SDO), .ALS_SDO_OE(ALS_SDO_OE),
    .busy(busy), .frame_done(frame_done), .underrun(underrun));

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int ur_cnt   = 0;
  int oe_hits  = 0;

  // Reference state: what a sensor with a holding register (or ramp) would return.
  logic [7:0] m_hold  = 8'h00;
  bit         m_fresh = 1'b0;
  logic [7:0] m_ramp  = 8'h00;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (underrun)   ur_cnt++;
    if (ALS_SDO_OE) oe_hits++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_sample(input logic [7:0] v);
    sample       = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
`ifndef ALS_RESPONDER_RAMP_EN
    m_hold  = v;
    m_fresh = 1'b1;
`endif
  endtask

  // One reader transaction: n_rise SCK rising edges, data captured just before each rise.
  task automatic run_frame(input string tag, input int n_rise, input bit idle_hi,
                           input int half, input bit late_wr, input logic [7:0] late_val);
    logic [15:0] cap, exp_frame;
    logic [7:0]  exp_s;
    bit          exp_ur;
    int          fd0, ur0;
`ifdef ALS_RESPONDER_RAMP_EN
    exp_s  = m_ramp;
    exp_ur = 1'b0;
`else
    exp_s  = m_hold;
    exp_ur = !m_fresh;
`endif
    exp_frame = 16'(exp_s) * 16'd32;   // 3 leading zeros, 8 sample bits, 5 trailing zeros
    cap = '0;
    ALS_SCK = idle_hi;
    tick(half);
    fd0 = fd_cnt;
    ur0 = ur_cnt;
    ALS_CS = 1'b0;
    tick(2);
    check({tag, ":oe_before_latency"}, ALS_SDO_OE, 0);
    if (late_wr) begin
      sample       = late_val;
      sample_valid = 1'b1;
    end
    tick(1);
    sample_valid = 1'b0;
    check({tag, ":oe_after_cs_fall"}, ALS_SDO_OE, 1);
    check({tag, ":busy"}, busy, 1);
`ifndef ALS_RESPONDER_RAMP_EN
    m_fresh = 1'b0;
    if (late_wr) begin
      m_hold  = late_val;
      m_fresh = 1'b1;
    end
`endif
    tick(half - 3);
    for (int i = 0; i < n_rise; i++) begin
      ALS_SCK = 1'b0;
      tick(half);
      cap = {cap[14:0], ALS_SDO};
      ALS_SCK = 1'b1;
      if (i == NBITS - 1) begin
        tick(2);
        check({tag, ":frame_done_early"}, frame_done, 0);
        tick(1);
        check({tag, ":frame_done_pulse"}, frame_done, 1);
        tick(1);
        check({tag, ":frame_done_width"}, frame_done, 0);
        tick(half - 4);
      end else begin
        tick(half);
      end
    end
    ALS_SCK = idle_hi;
    tick(half);
    if (n_rise == NBITS) begin
      check({tag, ":done_sdo"}, ALS_SDO, 0);
      check({tag, ":done_oe"}, ALS_SDO_OE, 1);
    end
    ALS_CS = 1'b1;
    tick(3);
    check({tag, ":oe_release"}, ALS_SDO_OE, 0);
    check({tag, ":busy_release"}, busy, 0);
    check({tag, ":sdo_release"}, ALS_SDO, 0);
    tick(half);
    if (n_rise == NBITS) check({tag, ":data"}, cap, exp_frame);
    check({tag, ":frame_done_count"}, fd_cnt - fd0, (n_rise == NBITS) ? 1 : 0);
    check({tag, ":underrun_count"}, ur_cnt - ur0, exp_ur ? 1 : 0);
`ifdef ALS_RESPONDER_RAMP_EN
    if (n_rise == NBITS) m_ramp = m_ramp + 8'd1;
`endif
  endtask

  initial begin
    int o0, n_rise, half;
    bit idle_hi;
    rst_n        = 1'b0;
    ALS_CS       = 1'b1;
    ALS_SCK      = 1'b0;
    sample       = 8'h00;
    sample_valid = 1'b0;
    tick(3);
    check("reset:sdo", ALS_SDO, 0);
    check("reset:oe", ALS_SDO_OE, 0);
    check("reset:busy", busy, 0);
    check("reset:frame_done", frame_done, 0);
    check("reset:underrun", underrun, 0);
    rst_n = 1'b1;
    tick(5);

`ifdef ALS_RESPONDER_RAMP_EN
    for (int k = 0; k < 128; k++) run_frame("ramp", NBITS, 1'b0, 6, 1'b0, 8'h00);
    write_sample(8'h5A);
    run_frame("ramp_abort", 7, 1'b0, 6, 1'b0, 8'h00);
    for (int k = 0; k < 129; k++) run_frame("ramp", NBITS, 1'b0, 6, 1'b0, 8'h00);
    check("ramp:wrapped", m_ramp, 8'h01);
`else
    write_sample(8'hA5);
    run_frame("first", NBITS, 1'b0, 25, 1'b0, 8'h00);
    run_frame("repeat_underrun", NBITS, 1'b0, 25, 1'b0, 8'h00);
    write_sample(8'h3C);
    run_frame("abort7", 7, 1'b0, 25, 1'b0, 8'h00);
    run_frame("after_abort", NBITS, 1'b0, 25, 1'b0, 8'h00);
    write_sample(8'hA5);
    run_frame("idle_high", NBITS, 1'b1, 25, 1'b0, 8'h00);
    write_sample(8'h11);
    run_frame("same_cycle_write", NBITS, 1'b0, 25, 1'b1, 8'h77);
    run_frame("after_same_cycle", NBITS, 1'b0, 25, 1'b0, 8'h00);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) write_sample(8'($urandom));
      idle_hi = 1'($urandom_range(0, 1));
      half    = int'($urandom_range(6, 30));
      n_rise  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : NBITS;
      run_frame("random", n_rise, idle_hi, half, 1'b0, 8'h00);
    end

    // Reset in the middle of a frame, then release with CS still low.
    write_sample(8'hC3);
    ALS_SCK = 1'b0;
    ALS_CS  = 1'b0;
    tick(10);
    ALS_SCK = 1'b1;
    tick(8);
    ALS_SCK = 1'b0;
    tick(8);
    check("midframe:busy", busy, 1);
    check("midframe:oe", ALS_SDO_OE, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst:oe", ALS_SDO_OE, 0);
    check("async_rst:sdo", ALS_SDO, 0);
    check("async_rst:busy", busy, 0);
    tick(2);
    rst_n   = 1'b1;
    m_hold  = 8'h00;
    m_fresh = 1'b0;
    o0 = oe_hits;
    for (int k = 0; k < 4; k++) begin
      ALS_SCK = ~ALS_SCK;
      tick(8);
    end
    tick(10);
    check("rst_release_cs_low:oe_cycles", oe_hits - o0, 0);
    check("rst_release_cs_low:busy", busy, 0);
    ALS_CS = 1'b1;
    tick(10);
    write_sample(8'hA5);
    run_frame("post_reset", NBITS, 1'b0, 25, 1'b0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
